// File: rtl/router_rr_if.sv
// Flit bundle of router_rr: per-input and per-output flit channels plus
// the combinational routing-table lookup.
interface router_rr_if #(
    parameter int NPORTS     = 5,
    parameter int ADDR_SZ    = 4,
    parameter int PAYLOAD_SZ = 8,
    parameter int BITS_DIR   = 3
);
    localparam int FW = PAYLOAD_SZ + ADDR_SZ;

    logic [NPORTS-1:0]    in_valid;
    logic [NPORTS*FW-1:0] in_data;
    logic [NPORTS-1:0]    in_busy;
    logic [NPORTS-1:0]    out_valid;
    logic [NPORTS*FW-1:0] out_data;
    logic [NPORTS-1:0]    out_busy;
    logic [ADDR_SZ-1:0]   table_addr;
    logic [BITS_DIR-1:0]  table_data;

    modport master (
        output in_valid, in_data, out_busy, table_data,
        input  in_busy, out_valid, out_data, table_addr
    );

    modport slave (
        input  in_valid, in_data, out_busy, table_data,
        output in_busy, out_valid, out_data, table_addr
    );
endinterface

// File: rtl/router_rr.sv
// Round-robin mesh router core: one FIFO per input, one head routed per cycle
// into a per-output register, with a windowed accept/drop monitor.
module router_rr #(
    parameter int ROUTERID    = -1,
    parameter int NPORTS      = 5,
    parameter int ADDR_SZ     = 4,
    parameter int PAYLOAD_SZ  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int BITS_DIR    = 3,
    parameter int SAMPLE_LOG2 = 10,
    parameter int CNT_W       = 20
) (
    input  logic             clk,
    input  logic             reset,
    router_rr_if.slave       bus,
    output logic [CNT_W-1:0] flit_counter,
    output logic [CNT_W-1:0] drop_counter
);
    localparam int FW = PAYLOAD_SZ + ADDR_SZ;
    localparam int PW = $clog2(NPORTS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [FW-1:0]          mem    [NPORTS][FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr [NPORTS];
    logic [AW-1:0]          rd_ptr [NPORTS];
    logic [CW-1:0]          count  [NPORTS];
    logic [NPORTS-1:0]      full, nonempty, free, wr_en, pop;
    logic [PW-1:0]          rr_ptr, sel;
    logic                   any, drop, grant, free_dst;
    logic [FW-1:0]          head;
    logic [SAMPLE_LOG2-1:0] win;
    logic [CNT_W-1:0]       run_acc, run_dr, acc;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Input stage: busy comes only from registered occupancy, so a pop never frees a slot early
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            full[i]     = (count[i] == CW'(FIFO_DEPTH));
            nonempty[i] = (count[i] != '0);
            free[i]     = ~bus.out_valid[i] | ~bus.out_busy[i];
        end
        wr_en = bus.in_valid & ~full;
    end

    assign bus.in_busy = full;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORTS; i++)
            if (wr_en[i]) mem[i][wr_ptr[i]] <= bus.in_data[i*FW +: FW];
    end

    // Arbiter stage: pick the first non-empty head from rr_ptr and route it
    always_comb begin
        int idx;
        any = 1'b0;
        sel = '0;
        idx = 0;
        for (int k = 0; k < NPORTS; k++) begin
            idx = (int'(rr_ptr) + k) % NPORTS;
            if (!any && nonempty[idx]) begin
                any = 1'b1;
                sel = PW'(idx);
            end
        end
        head           = mem[sel][rd_ptr[sel]];
        bus.table_addr = any ? head[ADDR_SZ-1:0] : '0;
        drop           = any && (int'(bus.table_data) >= NPORTS);
        free_dst       = 1'b0;
        for (int j = 0; j < NPORTS; j++)
            if (int'(bus.table_data) == j) free_dst = free[j];
        grant = any && !drop && free_dst;
        pop   = '0;
        if (drop || grant) pop[sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NPORTS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop[i])   rd_ptr[i] <= rd_ptr[i] + AW'(1);
                count[i] <= count[i] + CW'(wr_en[i]) - CW'(pop[i]);
            end
            // Advance past sel even on a stall so a blocked head cannot starve others
            if (any) rr_ptr <= (sel == PW'(NPORTS-1)) ? '0 : sel + PW'(1);
        end
    end

    // Output stage: one register per output, held while downstream is busy
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= '0;
            bus.out_data  <= '0;
        end else begin
            for (int j = 0; j < NPORTS; j++) begin
                if (grant && int'(bus.table_data) == j) begin
                    bus.out_valid[j]          <= 1'b1;
                    bus.out_data[j*FW +: FW] <= head;
                end else if (bus.out_valid[j] && !bus.out_busy[j]) begin
                    bus.out_valid[j] <= 1'b0;
                end
            end
        end
    end

    // Monitor stage: terminal-cycle events land in the published window
    assign acc = CNT_W'($countones(wr_en));

    always_ff @(posedge clk) begin
        if (reset) begin
            win          <= '0;
            run_acc      <= '0;
            run_dr       <= '0;
            flit_counter <= '0;
            drop_counter <= '0;
        end else begin
            win <= win + SAMPLE_LOG2'(1);
            if (&win) begin
                flit_counter <= sat_add(run_acc, acc);
                drop_counter <= sat_add(run_dr, CNT_W'(drop));
                run_acc      <= '0;
                run_dr       <= '0;
            end else begin
                run_acc <= sat_add(run_acc, acc);
                run_dr  <= sat_add(run_dr, CNT_W'(drop));
            end
        end
    end
endmodule

// File: tb/tb_router_rr.sv
// Directed bench for router_rr: latency, backpressure, fairness, stall skip,
// drops, windowed monitor and mid-window reset.
module tb_router_rr;
    localparam int NP = 5;
    localparam int AS = 4;
    localparam int PS = 8;
    localparam int FW = 12;
    localparam int BD = 3;
    localparam int SL = 3;
    localparam int CW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] flit_counter, drop_counter;
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc   = 0;

    router_rr_if #(.NPORTS(NP), .ADDR_SZ(AS), .PAYLOAD_SZ(PS), .BITS_DIR(BD)) bus ();

    router_rr #(
        .ROUTERID(7), .NPORTS(NP), .ADDR_SZ(AS), .PAYLOAD_SZ(PS), .FIFO_DEPTH(4),
        .BITS_DIR(BD), .SAMPLE_LOG2(SL), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .flit_counter(flit_counter), .drop_counter(drop_counter)
    );

    always #5 clk = ~clk;

    // Routing table: 3 -> port 1, 8..12 -> ports 0..4, 7 and 13..15 -> out of range
    function automatic logic [BD-1:0] route(input logic [AS-1:0] a);
        if (a == 4'd3) return 3'd1;
        if (a >= 4'd8) return BD'(a - 4'd8);
        return BD'(a);
    endfunction

    assign bus.table_data = route(bus.table_addr);

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic put(input int p, input logic [FW-1:0] f);
        bus.in_valid[p]          = 1'b1;
        bus.in_data[p*FW +: FW] = f;
    endtask

    function automatic logic [FW-1:0] odata(input int j);
        return bus.out_data[j*FW +: FW];
    endfunction

    int port_of [3] = '{0, 2, 3};
    int out_of  [3] = '{1, 3, 4};

    initial begin
        reset        = 1'b1;
        bus.in_valid = '0;
        bus.in_data  = '0;
        bus.out_busy = '0;
        repeat (2) @(negedge clk);
        chk_eq("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk_eq("rst_out_data",  64'(bus.out_data),  64'(0));
        chk_eq("rst_in_busy",   64'(bus.in_busy),   64'(0));
        chk_eq("rst_flit_cnt",  64'(flit_counter),  64'(0));
        chk_eq("rst_drop_cnt",  64'(drop_counter),  64'(0));
        reset = 1'b0;
        cyc   = 0;

        // Monitor: 1 flit in cycle 2, 2 flits in cycle 7 -> 3 published at cycle 8
        tick(); tick();
        put(0, {8'h11, 4'h8});
        tick();
        bus.in_valid = '0;
        repeat (4) tick();
        put(1, {8'h22, 4'h9});
        put(2, {8'h33, 4'hA});
        chk_eq("mon_before_end", 64'(flit_counter), 64'(0));
        tick();
        bus.in_valid = '0;
        chk_eq("mon_flit_cnt", 64'(flit_counter), 64'(3));
        chk_eq("mon_drop_cnt", 64'(drop_counter), 64'(0));
        repeat (4) tick();

        // Single flit: port 4, dest 3 -> output 1
        put(4, 12'hA53);
        tick();
        bus.in_valid = '0;
        chk_eq("single_table_addr", 64'(bus.table_addr), 64'(3));
        chk_eq("single_no_early",   64'(bus.out_valid),  64'(0));
        tick();
        chk_eq("single_valid", 64'(bus.out_valid), 64'(5'b00010));
        chk_eq("single_data",  64'(odata(1)),      64'(12'hA53));
        tick();
        chk_eq("single_drop_valid", 64'(bus.out_valid), 64'(0));

        // Backpressure: output 1 busy, 6 flits offered on port 0
        bus.out_busy[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            if (k == 4) chk_eq("bp_not_full", 64'(bus.in_busy[0]), 64'(0));
            if (k == 5) chk_eq("bp_full",     64'(bus.in_busy[0]), 64'(1));
            put(0, {8'hB1 + 8'(k), 4'h9});
        end
        tick();
        bus.in_valid = '0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            chk_eq("bp_valid", 64'(bus.out_valid), 64'(5'b00010));
            chk_eq("bp_data",  64'(odata(1)),      64'({8'hB1 + 8'(k), 4'h9}));
            if (k == 0) bus.out_busy = '0;
        end
        tick();
        chk_eq("bp_sixth_absent", 64'(bus.out_valid), 64'(0));

        // Drop: dest 7 on port 2, isolated in its own window
        while (cyc % 8 != 0) tick();
        put(2, {8'hDD, 4'h7});
        tick();
        bus.in_valid = '0;
        chk_eq("drop_table_addr", 64'(bus.table_addr), 64'(7));
        tick();
        chk_eq("drop_no_valid", 64'(bus.out_valid), 64'(0));
        tick();
        chk_eq("drop_popped",    64'(bus.table_addr), 64'(0));
        chk_eq("drop_no_valid2", 64'(bus.out_valid),  64'(0));
        while (cyc % 8 != 0) tick();
        chk_eq("drop_cnt",      64'(drop_counter), 64'(1));
        chk_eq("drop_flit_cnt", 64'(flit_counter), 64'(1));

        // Mid-window reset with flits buffered in registers and FIFOs
        bus.out_busy = '1;
        put(0, {8'hE1, 4'h8});
        put(3, {8'hE3, 4'hB});
        tick();
        put(0, {8'hE2, 4'h8});
        put(3, {8'hE4, 4'hB});
        tick();
        bus.in_valid = '0;
        tick(); tick();
        chk_eq("pre_rst_valid", 64'(bus.out_valid), 64'(5'b01001));
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        cyc          = 0;
        bus.out_busy = '0;
        chk_eq("mid_rst_valid",      64'(bus.out_valid),  64'(0));
        chk_eq("mid_rst_data",       64'(bus.out_data),   64'(0));
        chk_eq("mid_rst_in_busy",    64'(bus.in_busy),    64'(0));
        chk_eq("mid_rst_table_addr", 64'(bus.table_addr), 64'(0));
        chk_eq("mid_rst_flit_cnt",   64'(flit_counter),   64'(0));
        chk_eq("mid_rst_drop_cnt",   64'(drop_counter),   64'(0));

        // Fairness: ports 0,2,3 load 3 flits each; grants go 0,2,3 repeating
        for (int c = 1; c <= 11; c++) begin
            tick();
            bus.in_valid = '0;
            if (c <= 3)
                for (int i = 0; i < 3; i++)
                    put(port_of[i], {4'(port_of[i]), 4'(c - 1), 4'(out_of[i] + 8)});
            if (c >= 3) begin
                int g;
                g = c - 3;
                chk_eq("fair_valid", 64'(bus.out_valid), 64'(1 << out_of[g % 3]));
                chk_eq("fair_data",  64'(odata(out_of[g % 3])),
                       64'({4'(port_of[g % 3]), 4'(g / 3), 4'(out_of[g % 3] + 8)}));
            end
            if (c == 8) chk_eq("fair_flit_cnt", 64'(flit_counter), 64'(9));
        end
        tick();
        chk_eq("fair_idle", 64'(bus.out_valid), 64'(0));

        // Stall skip: port 0 waits on occupied output 2, port 1 passes to output 3
        bus.out_busy[2] = 1'b1;
        put(4, {8'hF0, 4'hA});
        tick();
        bus.in_valid = '0;
        tick();
        put(0, {8'hF1, 4'hA});
        put(1, {8'hF2, 4'hB});
        tick();
        bus.in_valid = '0;
        tick();
        chk_eq("stall_hold_valid", 64'(bus.out_valid), 64'(5'b00100));
        chk_eq("stall_hold_data",  64'(odata(2)),      64'({8'hF0, 4'hA}));
        tick();
        chk_eq("skip_valid", 64'(bus.out_valid), 64'(5'b01100));
        chk_eq("skip_data",  64'(odata(3)),      64'({8'hF2, 4'hB}));
        tick();
        chk_eq("stall_still_valid", 64'(bus.out_valid), 64'(5'b00100));
        chk_eq("stall_still_data",  64'(odata(2)),      64'({8'hF0, 4'hA}));
        bus.out_busy = '0;
        tick();
        chk_eq("unstall_valid", 64'(bus.out_valid), 64'(5'b00100));
        chk_eq("unstall_data",  64'(odata(2)),      64'({8'hF1, 4'hA}));
        tick();
        chk_eq("unstall_idle", 64'(bus.out_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
